wisard_frame_serializer: RTL

- Upstream feeder for the wisard classifier core.
- Accepts one input frame per sample as a stream of per-RAM addresses on a valid/ready handshake and buffers it in a ping-pong (two-bank) store.
- Replays each complete frame to the core as a gap-free sop/sink_valid/eop/addr/index burst of exactly N_RAMS cycles.
- Lets the source run ahead of classification by one frame, with back-pressure.

---
 rtl/wisard_frame_serializer_if.sv | 30 +++
 rtl/wisard_frame_serializer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wisard_frame_serializer_if.sv
// rtl/wisard_frame_serializer_if.sv - input word stream and output burst bundle for the wisard frame serializer
//
// Input stream : in_valid/in_ready handshake carrying in_addr, with in_last closing a frame.
// Output burst : sop/sink_valid/eop framed addr words tagged with their RAM index.
// slave  modport: serializer side (consumes the input stream, drives the burst).
// master modport: source/sink side (drives the input stream, observes the burst).
interface wisard_frame_serializer_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INDEX_WIDTH   = 7
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ADDRESS_WIDTH-1:0] in_addr;
  logic                     in_last;
  logic                     sop;
  logic                     sink_valid;
  logic                     eop;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [INDEX_WIDTH-1:0]   index;

  modport slave (
    input  in_valid, in_addr, in_last,
    output in_ready, sop, sink_valid, eop, addr, index
  );

  modport master (
    output in_valid, in_addr, in_last,
    input  in_ready, sop, sink_valid, eop, addr, index
  );
endinterface

// File: rtl/wisard_frame_serializer.sv
// rtl/wisard_frame_serializer.sv - ping-pong frame buffer replaying address frames as gap-free bursts
//
// Ports:
//   clk       : single rising-edge clock
//   rst_n     : asynchronous active-low reset, discards all buffered data
//   bus       : slave side of wisard_frame_serializer_if (input stream + output burst)
//   frame_err : one-cycle pulse when a frame ends early or its final word lacks in_last
//   busy      : a bank holds a committed frame or a burst is in progress
module wisard_frame_serializer #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INDEX_WIDTH   = 7,
  parameter int N_RAMS        = 98,
  parameter int GAP_CYCLES    = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  wisard_frame_serializer_if.slave    bus,
  output logic                        frame_err,
  output logic                        busy
);

  localparam int CW = (N_RAMS > 1) ? $clog2(N_RAMS) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_RAMS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  logic [ADDRESS_WIDTH-1:0] r_mem [2][N_RAMS];

  state_t                   r_state,     w_state_nxt;
  logic [1:0]               r_full,      w_full_nxt;
  logic                     r_wr_bank,   w_wr_bank_nxt;
  logic [CW-1:0]            r_wr_cnt,    w_wr_cnt_nxt;
  logic                     r_rd_bank,   w_rd_bank_nxt;
  logic [CW-1:0]            r_rd_cnt,    w_rd_cnt_nxt;
  logic [GW-1:0]            r_gap_cnt,   w_gap_cnt_nxt;
  logic                     r_in_ready;
  logic                     r_sop,       w_sop_nxt;
  logic                     r_valid,     w_valid_nxt;
  logic                     r_eop,       w_eop_nxt;
  logic [ADDRESS_WIDTH-1:0] r_addr,      w_addr_nxt;
  logic                     r_frame_err, w_err_nxt;
  logic                     w_acc;
  logic                     w_start;

  assign w_acc = bus.in_valid & r_in_ready;

  // Frame storage carries no reset: validity lives entirely in r_full.
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wr_bank][r_wr_cnt] <= bus.in_addr;
  end

  always_comb begin
    w_full_nxt    = r_full;
    w_wr_bank_nxt = r_wr_bank;
    w_wr_cnt_nxt  = r_wr_cnt;
    w_err_nxt     = 1'b0;
    w_state_nxt   = r_state;
    w_rd_bank_nxt = r_rd_bank;
    w_rd_cnt_nxt  = '0;
    w_gap_cnt_nxt = r_gap_cnt;
    w_sop_nxt     = 1'b0;
    w_valid_nxt   = 1'b0;
    w_eop_nxt     = 1'b0;
    w_addr_nxt    = '0;
    w_start       = 1'b0;

    // Write side: the word count alone decides the frame boundary; in_last only
    // cuts a frame short (discard) or flags a missing terminator (kept).
    if (w_acc) begin
      if (r_wr_cnt == LAST_CNT) begin
        w_full_nxt[r_wr_bank] = 1'b1;
        w_wr_cnt_nxt          = '0;
        w_wr_bank_nxt         = ~r_wr_bank;
        w_err_nxt             = ~bus.in_last;
      end else if (bus.in_last) begin
        w_wr_cnt_nxt = '0;
        w_err_nxt    = 1'b1;
      end else begin
        w_wr_cnt_nxt = r_wr_cnt + CW'(1);
      end
    end

    // Read side: the registered outputs always show word r_rd_cnt of r_rd_bank.
    case (r_state)
      S_IDLE: w_start = r_full[r_rd_bank];
      S_BURST: begin
        if (r_rd_cnt == LAST_CNT) begin
          // eop cycle ends here: release the bank; the write side may commit the
          // other bank on this same edge since it never targets a full bank.
          w_full_nxt[r_rd_bank] = 1'b0;
          w_rd_bank_nxt         = ~r_rd_bank;
          if (GAP_CYCLES > 0) begin
            w_state_nxt   = S_GAP;
            w_gap_cnt_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
            w_start     = r_full[~r_rd_bank];
          end
        end else begin
          w_rd_cnt_nxt = r_rd_cnt + CW'(1);
          w_valid_nxt  = 1'b1;
          w_eop_nxt    = (w_rd_cnt_nxt == LAST_CNT);
          w_addr_nxt   = r_mem[r_rd_bank][w_rd_cnt_nxt];
        end
      end
      S_GAP: begin
        // Leaving straight into a burst keeps the idle run at exactly GAP_CYCLES.
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_start     = r_full[r_rd_bank];
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_start) begin
      w_state_nxt  = S_BURST;
      w_rd_cnt_nxt = '0;
      w_sop_nxt    = 1'b1;
      w_valid_nxt  = 1'b1;
      w_addr_nxt   = r_mem[w_rd_bank_nxt][0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_gap_cnt   <= '0;
      r_in_ready  <= 1'b0;
      r_sop       <= 1'b0;
      r_valid     <= 1'b0;
      r_eop       <= 1'b0;
      r_addr      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_full      <= w_full_nxt;
      r_wr_bank   <= w_wr_bank_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_in_ready  <= ~w_full_nxt[w_wr_bank_nxt];
      r_sop       <= w_sop_nxt;
      r_valid     <= w_valid_nxt;
      r_eop       <= w_eop_nxt;
      r_addr      <= w_addr_nxt;
      r_frame_err <= w_err_nxt;
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.sop        = r_sop;
  assign bus.sink_valid = r_valid;
  assign bus.eop        = r_eop;
  assign bus.addr       = r_addr;
  assign bus.index      = INDEX_WIDTH'(r_rd_cnt);
  assign frame_err      = r_frame_err;
  assign busy           = (|r_full) | (r_state == S_BURST);

endmodule
